// File: rtl/mac_frame_arbiter.sv
// Frame-granular two-port round-robin arbiter merging two AXI-Stream feeds into one
// registered output stream, with oversize truncation and per-port frame counters.
module mac_frame_arbiter #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MAX_BEATS = 190
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din0,
  input  logic [KEEP_W-1:0] tkeep0,
  input  logic              tvalid0,
  input  logic              tlast0,
  output logic              tready0,
  input  logic [DATA_W-1:0] din1,
  input  logic [KEEP_W-1:0] tkeep1,
  input  logic              tvalid1,
  input  logic              tlast1,
  output logic              tready1,
  output logic [DATA_W-1:0] out,
  output logic [KEEP_W-1:0] out_keep,
  output logic              outvalid,
  output logic              tlast_out,
  input  logic              out_ready,
  output logic              grant,
  output logic              busy,
  output logic              err_oversize,
  output logic [15:0]       frames0,
  output logic [15:0]       frames1
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam int              CNT_W    = 10;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               last_grant;

  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               can_load;
  logic               accept;
  logic               at_limit;
  logic               frame_end;

  // Ready is derived from registered state and out_ready only, never from tvalid.
  always_comb begin
    sel_valid = grant ? tvalid1 : tvalid0;
    sel_last  = grant ? tlast1  : tlast0;
    sel_data  = grant ? din1    : din0;
    sel_keep  = grant ? tkeep1  : tkeep0;
    can_load  = !outvalid || out_ready;
    tready0   = 1'b0;
    tready1   = 1'b0;
    case (state)
      FWD: begin
        if (grant) tready1 = can_load;
        else       tready0 = can_load;
      end
      DROP: begin
        if (grant) tready1 = 1'b1;
        else       tready0 = 1'b1;
      end
      default: ;
    endcase
    accept    = sel_valid && (grant ? tready1 : tready0);
    at_limit  = (beat_cnt == LAST_IDX);
    frame_end = (state != IDLE) && accept && sel_last;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      out          <= '0;
      out_keep     <= '0;
      outvalid     <= 1'b0;
      tlast_out    <= 1'b0;
      err_oversize <= 1'b0;
      frames0      <= '0;
      frames1      <= '0;
    end else begin
      err_oversize <= 1'b0;

      if (state == FWD && accept) begin
        out       <= sel_data;
        out_keep  <= sel_keep;
        outvalid  <= 1'b1;
        tlast_out <= sel_last || at_limit;
      end else if (out_ready) begin
        outvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tvalid0 || tvalid1) begin
            grant    <= (tvalid0 && tvalid1) ? !last_grant : tvalid1;
            beat_cnt <= '0;
            state    <= FWD;
          end
        end
        FWD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (!sel_last && at_limit) begin
              err_oversize <= 1'b1;
              state        <= DROP;
            end
          end
        end
        default: ;
      endcase

      // Frame completion is shared by FWD and DROP: the source tlast always closes the frame.
      if (frame_end) begin
        if (grant) frames1 <= frames1 + 16'd1;
        else       frames0 <= frames0 + 16'd1;
        last_grant <= grant;
        state      <= IDLE;
      end
    end
  end

endmodule
